// File: rtl/sram_mem_stage_if.sv
// -----------------------------------------------------------------------------
// sram_mem_stage_if
// Pipeline-side bus between the execute stage and the memory-stage controller.
//   rd_en / wr_en : load / store request, held high until ready
//   address       : byte address (ALU result)
//   write_data    : store data
//   read_data     : loaded word
//   ready         : high when no access is pending or one completes this cycle
// master = pipeline (issues requests), slave = sram_mem_stage.
// -----------------------------------------------------------------------------
interface sram_mem_stage_if;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output rd_en, wr_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  rd_en, wr_en, address, write_data,
    output read_data, ready
  );
endinterface

// File: rtl/sram_mem_stage.sv
// -----------------------------------------------------------------------------
// sram_mem_stage
// Memory-stage controller. Turns one 32-bit LDR/STR into two back-to-back
// halfword accesses on a 16-bit asynchronous SRAM (low half first), and holds
// ready low while the access is in flight so earlier pipeline stages freeze.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : pipeline request/response bus (slave side)
//   sram_addr   : SRAM halfword address, registered and stable per phase
//   sram_dq     : SRAM bidirectional data bus
//   sram_we_n   : SRAM write enable, active-low
// -----------------------------------------------------------------------------
module sram_mem_stage #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          WAIT_CYCLES = 2,
  parameter int          SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst_n,
  sram_mem_stage_if.slave    bus,
  output logic [SRAM_AW-1:0] sram_addr,
  inout  wire  [15:0]        sram_dq,
  output logic               sram_we_n
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_e;

  localparam int             CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0]  LAST_CNT = CW'(WAIT_CYCLES - 1);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 op_wr_q, op_wr_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          data_q, data_d;
  logic [31:0]          read_data_q, read_data_d;
  logic [SRAM_AW-1:0]   sram_addr_q, sram_addr_d;
  logic                 drive_q, drive_d;
  logic [15:0]          dq_out_q, dq_out_d;

  logic                 last_cycle;
  logic                 phase_active;
  logic [SRAM_AW-2:0]   widx;

  // NOTE: every variable assigned here gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_wr_d     = op_wr_q;
    addr_d      = addr_q;
    data_d      = data_q;
    read_data_d = read_data_q;
    last_cycle  = (cnt_q == LAST_CNT);

    case (state_q)
      IDLE: begin
        if (bus.wr_en | bus.rd_en) begin
          state_d = LO;
          cnt_d   = '0;
          op_wr_d = bus.wr_en;        // a simultaneous read is dropped
          addr_d  = bus.address;
          data_d  = bus.write_data;
        end
      end
      LO: begin
        if (last_cycle) begin
          cnt_d   = '0;
          state_d = HI;
          if (!op_wr_q) read_data_d[15:0] = sram_dq;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HI: begin
        if (last_cycle) begin
          cnt_d   = '0;
          state_d = DONE;
          if (!op_wr_q) read_data_d[31:16] = sram_dq;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // SRAM-side outputs are decoded from the *next* state so the registered
    // pins change exactly at a phase boundary and stay stable through it.
    // Word index wraps silently; the low two address bits drop out in the shift.
    widx         = (SRAM_AW-1)'((addr_d - BASE_ADDR) >> 2);
    phase_active = (state_d == LO) | (state_d == HI);
    sram_addr_d  = phase_active ? {widx, (state_d == HI)} : '0;
    drive_d      = phase_active & op_wr_d;
    dq_out_d     = (state_d == HI) ? data_d[31:16] : data_d[15:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_wr_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      read_data_q <= '0;
      sram_addr_q <= '0;
      drive_q     <= 1'b0;
      dq_out_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_wr_q     <= op_wr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      read_data_q <= read_data_d;
      sram_addr_q <= sram_addr_d;
      drive_q     <= drive_d;
      dq_out_q    <= dq_out_d;
    end
  end

  // A request seen in IDLE pulls ready low in the same cycle it appears.
  assign bus.ready     = (state_q == DONE) |
                         ((state_q == IDLE) & ~bus.rd_en & ~bus.wr_en);
  assign bus.read_data = read_data_q;
  assign sram_addr     = sram_addr_q;
  assign sram_we_n     = ~drive_q;
  assign sram_dq       = drive_q ? dq_out_q : 16'bz;

endmodule
